// File: rtl/alu_result_checker_if.sv
// Bundle of stimulus, result and status signals between an ALU test generator and alu_result_checker.
// The master side drives the stimulus and result channels; the slave (checker) drives status.
interface alu_result_checker_if #(
  parameter int WIDTH = 32
);
  logic             exp_valid;
  logic             exp_ready;
  logic [WIDTH-1:0] exp_op1;
  logic [WIDTH-1:0] exp_op2;
  logic             exp_add;
  logic             exp_sub;
  logic             exp_cmp;
  logic [WIDTH:0]   exp_result;
  logic             res_valid;
  logic [WIDTH:0]   res_data;
  logic             pass_pulse;
  logic             fail_pulse;
  logic [15:0]      pass_cnt;
  logic [15:0]      fail_cnt;
  logic             gen_err;
  logic             orphan_err;
  logic             halted;
  logic [WIDTH:0]   fail_exp;
  logic [WIDTH:0]   fail_got;

  modport master (
    output exp_valid, exp_op1, exp_op2, exp_add, exp_sub, exp_cmp, exp_result,
    output res_valid, res_data,
    input  exp_ready, pass_pulse, fail_pulse, pass_cnt, fail_cnt,
    input  gen_err, orphan_err, halted, fail_exp, fail_got
  );

  modport slave (
    input  exp_valid, exp_op1, exp_op2, exp_add, exp_sub, exp_cmp, exp_result,
    input  res_valid, res_data,
    output exp_ready, pass_pulse, fail_pulse, pass_cnt, fail_cnt,
    output gen_err, orphan_err, halted, fail_exp, fail_got
  );
endinterface

// File: rtl/alu_result_checker.sv
// Scoreboard for an add/sub/cmp ALU: queues reference results computed from stimulus and
// compares them in order against DUT results, producing registered verdicts and statistics.
module alu_result_checker #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_checker_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           r_state, r_nextState;
  logic [WIDTH:0]   r_refMem [DEPTH];
  logic [DEPTH-1:0] r_cmpMem;
  logic [PW-1:0]    r_wrPtr, r_rdPtr;
  logic [PW:0]      r_count;
  logic             r_passPulse, r_failPulse;
  logic [15:0]      r_passCnt, r_failCnt;
  logic             r_genErr, r_orphanErr;
  logic [WIDTH:0]   r_failExp, r_failGot;

  logic           w_full, w_empty, w_expReady, w_push, w_pop, w_resAct;
  logic           w_oneHot, w_isAdd, w_isCmp, w_headCmp, w_match;
  logic           w_passV, w_failV;
  logic [WIDTH:0] w_ref, w_headRef;

  assign w_full   = (r_count == (PW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = bus.exp_valid && w_expReady;
  assign w_resAct = bus.res_valid && (r_state != HALT);
  assign w_pop    = w_resAct && !w_empty;

  // A malformed op select is flagged and falls back to add
  assign w_oneHot = (bus.exp_add ^ bus.exp_sub ^ bus.exp_cmp) &&
                    !(bus.exp_add && bus.exp_sub && bus.exp_cmp);
  assign w_isAdd  = !w_oneHot || bus.exp_add;
  assign w_isCmp  = w_oneHot && bus.exp_cmp;
  assign w_ref    = w_isAdd ? ({1'b0, bus.exp_op1} + {1'b0, bus.exp_op2})
                            : ({1'b0, bus.exp_op1} - {1'b0, bus.exp_op2});

  assign w_headRef = r_refMem[r_rdPtr];
  assign w_headCmp = r_cmpMem[r_rdPtr];
  assign w_match   = w_headCmp ?
                     ((w_headRef[WIDTH] == bus.res_data[WIDTH]) &&
                      ((w_headRef[WIDTH-1:0] == '0) == (bus.res_data[WIDTH-1:0] == '0)))
                   : (w_headRef == bus.res_data);
  assign w_passV   = w_pop && w_match;
  assign w_failV   = w_resAct && (w_empty || !w_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= r_nextState;
  end

  always_comb begin
    r_nextState = r_state;
    w_expReady  = !w_full && (r_state != HALT);
    case (r_state)
      IDLE: begin
        if (w_failV && (STOP_ON_FAIL != 0)) r_nextState = HALT;
        else if (w_push || w_resAct)        r_nextState = RUN;
      end
      RUN: begin
        if (w_failV && (STOP_ON_FAIL != 0))     r_nextState = HALT;
        else if (w_empty && !w_push && !w_resAct) r_nextState = IDLE;
      end
      HALT:    r_nextState = HALT;
      default: r_nextState = IDLE;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_refMem[r_wrPtr] <= w_ref;
      r_cmpMem[r_wrPtr] <= w_isCmp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_passPulse <= 1'b0;
      r_failPulse <= 1'b0;
      r_passCnt   <= '0;
      r_failCnt   <= '0;
      r_genErr    <= 1'b0;
      r_orphanErr <= 1'b0;
      r_failExp   <= '0;
      r_failGot   <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_passPulse <= w_passV;
      r_failPulse <= w_failV;
      if (w_passV && (r_passCnt != 16'hFFFF)) r_passCnt <= r_passCnt + 1'b1;
      if (w_failV && (r_failCnt != 16'hFFFF)) r_failCnt <= r_failCnt + 1'b1;
      if (w_push && (!w_oneHot || (bus.exp_result != w_ref))) r_genErr <= 1'b1;
      if (w_resAct && w_empty) r_orphanErr <= 1'b1;
      // Only the first failure is captured; a zero fail count marks that first failure
      if (w_failV && (r_failCnt == '0)) begin
        r_failExp <= w_empty ? '0 : w_headRef;
        r_failGot <= bus.res_data;
      end
    end
  end

  assign bus.exp_ready  = w_expReady;
  assign bus.pass_pulse = r_passPulse;
  assign bus.fail_pulse = r_failPulse;
  assign bus.pass_cnt   = r_passCnt;
  assign bus.fail_cnt   = r_failCnt;
  assign bus.gen_err    = r_genErr;
  assign bus.orphan_err = r_orphanErr;
  assign bus.halted     = (r_state == HALT);
  assign bus.fail_exp   = r_failExp;
  assign bus.fail_got   = r_failGot;
endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a vector table for single transactions plus
// hand-written sequences for queueing, overflow, orphan/halt and mid-operation reset.
module tb_alu_result_checker;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_checker_if #(.WIDTH(WIDTH)) ifA ();
  alu_result_checker_if #(.WIDTH(WIDTH)) ifB ();

  alu_result_checker #(.WIDTH(WIDTH), .DEPTH(4), .STOP_ON_FAIL(0)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave));
  alu_result_checker #(.WIDTH(WIDTH), .DEPTH(4), .STOP_ON_FAIL(1)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB.slave));

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        add;
    logic        sub;
    logic        cmp;
    logic [32:0] expRes;
    logic [32:0] resData;
    logic        expPass;
  } vec_t;

  vec_t vecs[10];
  int nChecks = 0;
  int nFails = 0;
  int passModel = 0;
  int failModel = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic clearInputs();
    ifA.exp_valid = 1'b0; ifA.exp_op1 = '0; ifA.exp_op2 = '0;
    ifA.exp_add = 1'b0; ifA.exp_sub = 1'b0; ifA.exp_cmp = 1'b0;
    ifA.exp_result = '0; ifA.res_valid = 1'b0; ifA.res_data = '0;
    ifB.exp_valid = 1'b0; ifB.exp_op1 = '0; ifB.exp_op2 = '0;
    ifB.exp_add = 1'b0; ifB.exp_sub = 1'b0; ifB.exp_cmp = 1'b0;
    ifB.exp_result = '0; ifB.res_valid = 1'b0; ifB.res_data = '0;
  endtask

  task automatic applyStimulus(input logic [31:0] op1, input logic [31:0] op2,
                               input logic add, input logic sub, input logic cmp,
                               input logic [32:0] expRes);
    ifA.exp_valid = 1'b1; ifA.exp_op1 = op1; ifA.exp_op2 = op2;
    ifA.exp_add = add; ifA.exp_sub = sub; ifA.exp_cmp = cmp;
    ifA.exp_result = expRes;
  endtask

  task automatic setRes(input logic [32:0] data);
    ifA.res_valid = 1'b1;
    ifA.res_data  = data;
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 33'h1_0000_0000, 33'h1_0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 33'h0_2345_6789, 33'h0_2345_6789, 1'b1};
    vecs[2] = '{32'd10, 32'd3, 1'b0, 1'b1, 1'b0, 33'h0_0000_0007, 33'h0_0000_0007, 1'b1};
    vecs[3] = '{32'd0, 32'd1, 1'b0, 1'b1, 1'b0, 33'h1_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0};
    vecs[4] = '{32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 33'h0_0000_0000, 33'h0_0000_0000, 1'b1};
    vecs[5] = '{32'd3, 32'd5, 1'b0, 1'b0, 1'b1, 33'h1_FFFF_FFFE, 33'h1_0000_0001, 1'b1};
    vecs[6] = '{32'd9, 32'd2, 1'b0, 1'b0, 1'b1, 33'h0_0000_0007, 33'h0_0000_0001, 1'b1};
    vecs[7] = '{32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 33'h0_0000_0000, 33'h0_0000_0007, 1'b0};
    vecs[8] = '{32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 33'h0_0000_0003, 33'h0_0000_0004, 1'b0};
    vecs[9] = '{32'd2, 32'd9, 1'b0, 1'b0, 1'b1, 33'h1_FFFF_FFF9, 33'h0_0000_0000, 1'b0};

    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_exp_ready", ifA.exp_ready, 1);
    checkOutput("rst_pass_cnt", ifA.pass_cnt, 0);
    checkOutput("rst_fail_cnt", ifA.fail_cnt, 0);
    checkOutput("rst_pulses", {ifA.pass_pulse, ifA.fail_pulse}, 0);
    checkOutput("rst_flags", {ifA.gen_err, ifA.orphan_err, ifA.halted}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single push followed by its result one cycle later
    for (int i = 0; i < 10; i++) begin
      clearInputs();
      applyStimulus(vecs[i].op1, vecs[i].op2, vecs[i].add, vecs[i].sub, vecs[i].cmp, vecs[i].expRes);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_no_pulse", i), {ifA.pass_pulse, ifA.fail_pulse}, 0);
      clearInputs();
      setRes(vecs[i].resData);
      @(negedge clk);
      clearInputs();
      if (vecs[i].expPass) passModel++; else failModel++;
      checkOutput($sformatf("vec%0d_pass_pulse", i), ifA.pass_pulse, vecs[i].expPass);
      checkOutput($sformatf("vec%0d_fail_pulse", i), ifA.fail_pulse, !vecs[i].expPass);
      checkOutput($sformatf("vec%0d_pass_cnt", i), ifA.pass_cnt, passModel);
      checkOutput($sformatf("vec%0d_fail_cnt", i), ifA.fail_cnt, failModel);
    end
    checkOutput("cap_fail_exp", ifA.fail_exp, 33'h1_FFFF_FFFF);
    checkOutput("cap_fail_got", ifA.fail_got, 33'h0_FFFF_FFFF);
    checkOutput("tbl_flags", {ifA.gen_err, ifA.orphan_err, ifA.halted}, 0);

    // cmp 5,5 twice with a push overlapping the first pop
    clearInputs();
    applyStimulus(32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 33'h0);
    @(negedge clk);
    clearInputs();
    applyStimulus(32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 33'h0);
    setRes(33'h0);
    @(negedge clk);
    clearInputs();
    checkOutput("cmp_first_pass", ifA.pass_pulse, 1);
    setRes(33'h7);
    @(negedge clk);
    clearInputs();
    passModel++; failModel++;
    checkOutput("cmp_second_fail", ifA.fail_pulse, 1);
    checkOutput("cmp_pass_cnt", ifA.pass_cnt, passModel);
    checkOutput("cmp_fail_cnt", ifA.fail_cnt, failModel);
    checkOutput("cap_kept_first", ifA.fail_exp, 33'h1_FFFF_FFFF);

    // Fill the queue, then a blocked push alongside a pop
    for (int k = 0; k < 4; k++) begin
      clearInputs();
      applyStimulus(32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 33'h2);
      @(negedge clk);
    end
    clearInputs();
    checkOutput("full_exp_ready", ifA.exp_ready, 0);
    applyStimulus(32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 33'hA);
    setRes(33'h2);
    @(negedge clk);
    clearInputs();
    checkOutput("after_pop_ready", ifA.exp_ready, 1);
    checkOutput("full_pop_pass", ifA.pass_pulse, 1);
    for (int k = 0; k < 3; k++) begin
      setRes(33'h2);
      @(negedge clk);
      clearInputs();
      checkOutput($sformatf("drain%0d_pass", k), ifA.pass_pulse, 1);
    end
    setRes(33'h2);
    @(negedge clk);
    clearInputs();
    passModel += 4; failModel++;
    checkOutput("drain_orphan_fail", ifA.fail_pulse, 1);
    checkOutput("drain_orphan_err", ifA.orphan_err, 1);
    checkOutput("drain_pass_cnt", ifA.pass_cnt, passModel);
    checkOutput("drain_fail_cnt", ifA.fail_cnt, failModel);
    checkOutput("nostop_halted", ifA.halted, 0);

    // Orphan result on the stop-on-fail instance
    ifB.res_valid = 1'b1;
    ifB.res_data  = 33'h5;
    @(negedge clk);
    clearInputs();
    checkOutput("B_fail_pulse", ifB.fail_pulse, 1);
    checkOutput("B_orphan_err", ifB.orphan_err, 1);
    checkOutput("B_fail_cnt", ifB.fail_cnt, 1);
    checkOutput("B_halted", ifB.halted, 1);
    checkOutput("B_exp_ready", ifB.exp_ready, 0);
    checkOutput("B_fail_exp", ifB.fail_exp, 0);
    checkOutput("B_fail_got", ifB.fail_got, 33'h5);
    ifB.exp_valid = 1'b1; ifB.exp_op1 = 32'd1; ifB.exp_op2 = 32'd1;
    ifB.exp_add = 1'b1; ifB.exp_result = 33'h2;
    ifB.res_valid = 1'b1; ifB.res_data = 33'h0;
    @(negedge clk);
    clearInputs();
    checkOutput("B_halt_no_pulse", {ifB.pass_pulse, ifB.fail_pulse}, 0);
    checkOutput("B_halt_cnts", {ifB.pass_cnt, ifB.fail_cnt}, {16'd0, 16'd1});
    checkOutput("B_still_halted", ifB.halted, 1);

    // Generator errors, then reset with entries queued and a verdict in flight
    applyStimulus(32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 33'h3);
    @(negedge clk);
    clearInputs();
    checkOutput("gen_err_mismatch", ifA.gen_err, 1);
    applyStimulus(32'd4, 32'd1, 1'b1, 1'b1, 1'b0, 33'h5);
    @(negedge clk);
    clearInputs();
    setRes(33'h2);
    @(negedge clk);
    clearInputs();
    checkOutput("gen_err_uses_ref", ifA.pass_pulse, 1);
    setRes(33'h5);
    @(negedge clk);
    clearInputs();
    checkOutput("nonhot_as_add", ifA.pass_pulse, 1);
    applyStimulus(32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 33'h2);
    @(negedge clk);
    clearInputs();
    applyStimulus(32'd2, 32'd2, 1'b1, 1'b0, 1'b0, 33'h4);
    setRes(33'h2);
    @(negedge clk);
    clearInputs();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_exp_ready", ifA.exp_ready, 1);
    checkOutput("mid_rst_cnts", {ifA.pass_cnt, ifA.fail_cnt}, 0);
    checkOutput("mid_rst_pulses", {ifA.pass_pulse, ifA.fail_pulse}, 0);
    checkOutput("mid_rst_flags", {ifA.gen_err, ifA.orphan_err, ifA.halted}, 0);
    checkOutput("mid_rst_capture", {ifA.fail_exp, ifA.fail_got}, 0);
    checkOutput("mid_rst_B_halted", {ifB.halted, ifB.exp_ready}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_no_pulse", {ifA.pass_pulse, ifA.fail_pulse}, 0);
    setRes(33'h2);
    @(negedge clk);
    clearInputs();
    checkOutput("post_rst_orphan_fail", ifA.fail_pulse, 1);
    checkOutput("post_rst_orphan_err", ifA.orphan_err, 1);
    checkOutput("post_rst_cnts", {ifA.pass_cnt, ifA.fail_cnt}, {16'd0, 16'd1});
    checkOutput("post_rst_capture", {ifA.fail_exp, ifA.fail_got}, {33'h0, 33'h2});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand width; results are WIDTH+1 bits.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, at least 2), setting the number of outstanding expected-transaction queue entries.
REQ-003 The block SHALL have parameter STOP_ON_FAIL, default 0; when 1, the first failure freezes checking.
REQ-004 Port clk, input, 1: single clock, all state on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port exp_valid, input, 1: stimulus transaction present.
REQ-007 Port exp_ready, output, 1: queue can accept a transaction.
REQ-008 Port exp_op1 and exp_op2, input, WIDTH each: operands.
REQ-009 Port exp_add, exp_sub and exp_cmp, input, 1 each: one-hot operation select.
REQ-010 Port exp_result, input, WIDTH+1: generator-supplied expected result.
REQ-011 Port res_valid, input, 1: DUT result present; there is no backpressure on this port.
REQ-012 Port res_data, input, WIDTH+1: DUT result.
REQ-013 Port pass_pulse and fail_pulse, output, 1 each: one-cycle verdict strobes.
REQ-014 Port pass_cnt and fail_cnt, output, 16 each: saturating verdict counters.
REQ-015 Port gen_err, orphan_err and halted, output, 1 each: sticky status flags.
REQ-016 Port fail_exp and fail_got, output, WIDTH+1 each: captured data from the first failure.

Function
REQ-017 The queue SHALL be a DEPTH-entry FIFO; a push occurs when exp_valid and exp_ready are both high.
REQ-018 exp_ready SHALL be high when the queue is not full and the state is not HALT.
- A push at full is blocked even if a pop occurs in the same cycle.
REQ-019 On push, the block SHALL compute the reference value in the same cycle.
- add: ref = op1+op2, zero-extended to WIDTH+1 bits.
- sub or cmp: ref = op1-op2 modulo 2^(WIDTH+1).
REQ-020 On push, if exp_result differs from ref, gen_err SHALL set, and the stored ref SHALL be used for checking.
REQ-021 On push, if the op select is not one-hot, gen_err SHALL set and the entry SHALL be treated as add.
REQ-022 Each res_valid cycle SHALL pop the queue head when the queue is not empty.
- Pointers wrap modulo DEPTH.
REQ-023 A push and a pop in the same cycle SHALL both occur; the count is unchanged.
REQ-024 There SHALL be no empty-queue bypass.
REQ-025 Compare rule for add and sub entries: all WIDTH+1 bits match.
REQ-026 Compare rule for cmp entries: only the borrow bit [WIDTH] and the zero flag (bits [WIDTH-1:0] all zero) must match.
REQ-027 The verdict SHALL be registered: pass_pulse or fail_pulse asserts exactly one cycle after the res_valid cycle, and counters update on that same edge.
REQ-028 res_valid with an empty queue SHALL set orphan_err and produce a fail with fail_exp = 0.
REQ-029 Counters SHALL saturate at 0xFFFF.
REQ-030 On the first fail only, fail_exp (ref) and fail_got (res_data) SHALL be captured.
REQ-031 The state machine SHALL have states IDLE, RUN and HALT, with these transitions:
- IDLE to RUN on the first push or res_valid.
- RUN to IDLE when the queue is empty and no verdict is pending.
- RUN to HALT on a fail when STOP_ON_FAIL = 1.
- HALT is left only by reset.
REQ-032 In HALT, pushes and results SHALL be ignored, counters frozen, and halted = 1.

Reset
REQ-033 While rst_n is low, the block SHALL hold:
- state = IDLE and queue empty, exp_ready = 1;
- pulses, counters, flags and capture registers all zero.
REQ-034 A reset asserted mid-operation SHALL discard queued entries and any pending verdict; no pulse is produced after reset is released.

Verification
REQ-035 Push add 0xFFFFFFFF + 0x00000001, exp_result 0x100000000; res_data 0x100000000 one cycle later -> pass_pulse one cycle after res_valid, pass_cnt = 1.
REQ-036 Push sub 0 - 1; res_data 0x0FFFFFFFF -> fail_pulse, fail_cnt = 1, fail_exp = 0x1FFFFFFFF, fail_got = 0x0FFFFFFFF.
REQ-037 Push cmp 5,5, then two pops with res_data 0x000000000 and 0x000000007, pushing 5,5 again before the second -> first pass, second fail.
REQ-038 Push four transactions with res_valid low -> exp_ready = 0; a fifth push with a simultaneous res_valid is blocked; count stays 3 after the pop.
REQ-039 res_valid with an empty queue -> orphan_err = 1, fail_cnt = 1; with STOP_ON_FAIL = 1 -> halted = 1 and exp_ready = 0.
REQ-040 Push add 1+1 with exp_result 0x3, then rst_n low for one cycle mid-queue -> gen_err = 1 before reset; all outputs return to reset values afterwards.
